// File: rtl/z80_bus_responder.sv
// z80_bus_responder: synchronous Z80 bus slave for the tv80 benches.
// A byte memory serves both memory cycles and an I/O window at page IO_PAGE.
// Each bus cycle can take programmable wait states. Interrupt acknowledge
// returns a fixed vector. Every committed CPU write is logged in a FIFO.
// Ports:
//   clk, reset          bus clock, asynchronous active-high reset
//   m1_n .. rfsh_n, A   CPU bus strobes and address
//   dout / di           CPU write data in / read data out (registered)
//   wait_n              wait request to CPU (registered)
//   h_we/h_addr/h_wdata host write port; h_rdata registered host read data
//   h_drop              one-cycle pulse: host write lost to a CPU write commit
//   log_*               write-log FIFO: valid/ready/head data/occupancy/overflow
module z80_bus_responder #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [7:0]  IO_PAGE   = 8'h10,
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned IO_WAIT   = 1,
    parameter logic [7:0]  INTA_VEC  = 8'hFF,
    parameter int unsigned LOG_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m1_n,
    input  logic                         mreq_n,
    input  logic                         iorq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic                         rfsh_n,
    input  logic [15:0]                  A,
    input  logic [7:0]                   dout,
    output logic [7:0]                   di,
    output logic                         wait_n,
    input  logic                         h_we,
    input  logic [ADDR_W-1:0]            h_addr,
    input  logic [7:0]                   h_wdata,
    output logic [7:0]                   h_rdata,
    output logic                         h_drop,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [24:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_overflow
);

    localparam int unsigned PTR_W    = $clog2(LOG_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned MEM_SIZE = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [7:0]        mem [MEM_SIZE];
    logic [24:0]       log_mem [LOG_DEPTH];

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              cyc_io_q, cyc_io_d;
    logic              cyc_wr_q, cyc_wr_d;

    logic              mem_cyc, io_cyc, inta, cyc_start, bus_idle;
    logic [3:0]        start_cnt;
    logic              commit, commit_io, commit_wr, wait_n_d;
    logic              cpu_we, cpu_re;
    logic [ADDR_W-1:0] eff_addr;
    logic [24:0]       log_entry;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              log_full, log_push, log_push_ok, log_pop;

    // Bus cycle qualification; refresh cycles never qualify.
    assign mem_cyc   = !mreq_n & rfsh_n & (!rd_n | !wr_n);
    assign io_cyc    = !iorq_n & m1_n & (!rd_n | !wr_n);
    assign inta      = !iorq_n & !m1_n;
    assign cyc_start = mem_cyc | io_cyc;
    assign bus_idle  = rd_n & wr_n & mreq_n & iorq_n;
    assign start_cnt = io_cyc ? 4'(IO_WAIT) : 4'(MEM_WAIT);

    // State register plus the per-cycle wait counter and latched cycle kind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            cyc_io_q <= 1'b0;
            cyc_wr_q <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cyc_io_q <= cyc_io_d;
            cyc_wr_q <= cyc_wr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cyc_io_d = cyc_io_q;
        cyc_wr_d = cyc_wr_q;
        case (state)
            ST_IDLE: begin
                if (cyc_start) begin
                    cnt_d    = start_cnt;
                    cyc_io_d = io_cyc;
                    cyc_wr_d = !wr_n;
                    state_d  = (start_cnt == 4'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus_idle) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: commit strobe, cycle kind for the commit, next wait_n.
    always_comb begin
        commit    = 1'b0;
        commit_io = cyc_io_q;
        commit_wr = cyc_wr_q;
        wait_n_d  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (cyc_start) begin
                    commit_io = io_cyc;
                    commit_wr = !wr_n;
                    if (start_cnt == 4'd0) begin
                        commit = 1'b1;
                    end else begin
                        wait_n_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    commit = 1'b1;
                end else begin
                    wait_n_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Reset suppresses any commit so an aborted cycle leaves no trace.
    assign cpu_we    = commit & commit_wr & !reset;
    assign cpu_re    = commit & !commit_wr & !reset;
    assign eff_addr  = commit_io ? ADDR_W'({IO_PAGE, A[7:0]}) : ADDR_W'(A);
    assign log_entry = {commit_io, 16'(eff_addr), dout};

    // Byte memory; a CPU write commit takes priority over the host port.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[eff_addr] <= dout;
        end else if (h_we) begin
            mem[h_addr] <= h_wdata;
        end
    end

    // Registered bus and host outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            di      <= 8'h00;
            wait_n  <= 1'b1;
            h_rdata <= 8'h00;
            h_drop  <= 1'b0;
        end else begin
            if (cpu_re) begin
                di <= mem[eff_addr];
            end else if (inta) begin
                di <= INTA_VEC;
            end else begin
                di <= mem[ADDR_W'(A)];
            end
            wait_n  <= wait_n_d;
            h_rdata <= mem[h_addr];
            h_drop  <= h_we & cpu_we;
        end
    end

    // Write-log FIFO; a push while full is accepted only if a pop frees a slot.
    assign log_full    = (log_count == CNT_W'(LOG_DEPTH));
    assign log_valid   = (log_count != '0);
    assign log_pop     = log_valid & log_ready;
    assign log_push    = cpu_we;
    assign log_push_ok = log_push & (!log_full | log_pop);
    assign log_data    = log_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_count    <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (log_push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (log_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({log_push_ok, log_pop})
                2'b10:   log_count <= log_count + CNT_W'(1);
                2'b01:   log_count <= log_count - CNT_W'(1);
                default: log_count <= log_count;
            endcase
            if (log_push & log_full & !log_pop) begin
                log_overflow <= 1'b1;
            end
        end
    end

    // Log storage is not reset; only the pointers define valid entries.
    always_ff @(posedge clk) begin
        if (log_push_ok) begin
            log_mem[wr_ptr] <= log_entry;
        end
    end

endmodule
